// File: rtl/vcu_insn_dispatcher_if.sv
// vcu_insn_dispatcher_if: enqueue handshake between the instruction loader and the dispatcher
// Signals: insn_in/insn_ch/insn_valid from the loader, insn_ready (FIFO not full) back to it.
interface vcu_insn_dispatcher_if #(
  parameter int INSN_WIDTH = 128,
  parameter int CH_W = 3
);
  logic [INSN_WIDTH-1:0] insn_in;
  logic [CH_W-1:0] insn_ch;
  logic insn_valid;
  logic insn_ready;
  modport master (output insn_in, insn_ch, insn_valid, input insn_ready);
  modport slave (input insn_in, insn_ch, insn_valid, output insn_ready);
endinterface

// File: rtl/vcu_insn_dispatcher.sv
// vcu_insn_dispatcher: in-order FIFO dispatch of VCU instructions to NUM_CH channels, issue-and-wait per channel
// Ports: clk, rst (async active-low); insn (enqueue handshake); insn_out/work_en per-channel issue;
// vcu_done per-channel done level; timeout_limit (0 = off); err_clr, err_timeout, err_bad_ch sticky errors;
// done_cnt completions; fifo_level occupancy; all_idle when FIFO empty and every channel idle.
module vcu_insn_dispatcher #(
  parameter int INSN_WIDTH = 128,
  parameter int DEPTH = 16,
  parameter int NUM_CH = 2,
  parameter int CH_W = 3,
  parameter int TO_W = 24
) (
  input logic clk,
  input logic rst,
  vcu_insn_dispatcher_if.slave insn,
  output logic [NUM_CH*INSN_WIDTH-1:0] insn_out,
  output logic [NUM_CH-1:0] work_en,
  input logic [NUM_CH-1:0] vcu_done,
  input logic [TO_W-1:0] timeout_limit,
  input logic err_clr,
  output logic [NUM_CH-1:0] err_timeout,
  output logic err_bad_ch,
  output logic [15:0] done_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic all_idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int NX = 1 << CH_W;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  typedef enum logic {IDLE, BUSY} st_t;
  st_t st [NUM_CH];
  st_t st_n [NUM_CH];
  logic [CH_W+INSN_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CH_W-1:0] head_ch;
  logic [NUM_CH-1:0] busy, done_q, disp, fall, to_hit;
  logic [NX-1:0] busy_x;
  logic [TO_W-1:0] cnt [NUM_CH];
  logic [15:0] done_inc;
  logic push, pop, bad;
  assign insn.insn_ready = fifo_level != FULL;
  assign push = insn.insn_valid & insn.insn_ready;
  assign head_ch = mem[rd_ptr][INSN_WIDTH +: CH_W];
  assign bad = 32'(head_ch) >= NUM_CH;
  // Zero-extend so any channel-select code indexes safely; out-of-range heads are caught by bad.
  assign busy_x = NX'(busy);
  assign pop = (fifo_level != '0) & (bad | ~busy_x[head_ch]);
  assign all_idle = (fifo_level == '0) & ~|busy;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign busy[c] = st[c] == BUSY;
    assign disp[c] = pop & ~bad & (32'(head_ch) == c);
    assign fall[c] = busy[c] & done_q[c] & ~vcu_done[c];
    // Fires on the edge that ends the timeout_limit-th busy cycle; a simultaneous fall wins as completion.
    assign to_hit[c] = busy[c] & ~fall[c] & (timeout_limit != '0) & ((cnt[c] + 1'b1) == timeout_limit);
  end
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      st_n[c] = disp[c] ? BUSY : (fall[c] | to_hit[c]) ? IDLE : st[c];
  end
  always_comb begin
    done_inc = '0;
    for (int c = 0; c < NUM_CH; c++) done_inc = done_inc + 16'(fall[c]);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) st[c] <= IDLE;
    end else begin
      for (int c = 0; c < NUM_CH; c++) st[c] <= st_n[c];
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {insn.insn_ch, insn.insn_in};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      done_q <= '0;
      work_en <= '0;
      insn_out <= '0;
      err_timeout <= '0;
      err_bad_ch <= 1'b0;
      done_cnt <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      done_q <= vcu_done;
      work_en <= disp;
      err_timeout <= (err_clr ? '0 : err_timeout) | to_hit;
      err_bad_ch <= (~err_clr & err_bad_ch) | (pop & bad);
      done_cnt <= done_cnt + done_inc;
      for (int c = 0; c < NUM_CH; c++) begin
        if (disp[c]) insn_out[c*INSN_WIDTH +: INSN_WIDTH] <= mem[rd_ptr][INSN_WIDTH-1:0];
        cnt[c] <= disp[c] ? '0 : busy[c] ? cnt[c] + 1'b1 : cnt[c];
      end
    end
  end
endmodule

// File: doc/vcu_insn_dispatcher.md
# vcu_insn_dispatcher

Instruction dispatcher between the host/instruction loader and one or more VCU instances. It buffers incoming 128-bit VCU instructions in a FIFO and issues each to its target VCU channel with a one-cycle `work_en` pulse. It then waits for that channel's `vcu_done` falling edge before issuing the channel's next instruction. It generalises single-VCU issue-and-wait sequencing to N channels, a parametrised queue depth, a completion timeout and status counters.

## Interface
- `INSN_WIDTH`, 128, instruction width.
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `NUM_CH`, 2, number of VCU channels, 1..8.
- `CH_W`, 3, width of the channel-select field; NUM_CH ≤ 2^CH_W.
- `TO_W`, 24, timeout counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `insn_in`  in  INSN_WIDTH  instruction to enqueue.
- `insn_ch`  in  CH_W  target channel of `insn_in`.
- `insn_valid`  in  1  enqueue request.
- `insn_ready`  out  1  FIFO not full; reset 1.
- `insn_out`  out  NUM_CH*INSN_WIDTH  per-channel held instruction, channel c at [c*INSN_WIDTH +: INSN_WIDTH]; reset 0.
- `work_en`  out  NUM_CH  per-channel one-cycle start pulse; reset 0.
- `vcu_done`  in  NUM_CH  per-channel done level from the VCU.
- `timeout_limit`  in  TO_W  busy-cycle limit; 0 disables the timeout.
- `err_clr`  in  1  clears the sticky error bits.
- `err_timeout`  out  NUM_CH  sticky per-channel timeout flag; reset 0.
- `err_bad_ch`  out  1  sticky flag for a channel select ≥ NUM_CH; reset 0.
- `done_cnt`  out  16  completed instructions, wraps; reset 0.
- `fifo_level`  out  $clog2(DEPTH)+1  occupancy; reset 0.
- `all_idle`  out  1  FIFO empty and all channels IDLE; reset 1.

## Operation
- **Enqueue:** the FIFO stores {insn_ch, insn_in}. A push occurs when `insn_valid & insn_ready`. `insn_ready = (fifo_level != DEPTH)`. A push while full is not accepted, even if a pop occurs in the same cycle. Push and pop in the same cycle when not full is allowed, and the level is unchanged.
- **Channel FSM**, one per channel: IDLE → BUSY → IDLE.
  - IDLE → BUSY on dispatch.
  - BUSY → IDLE on a detected `vcu_done` fall, or on timeout.
- **Dispatch:** dispatch is strictly in order, with head-of-line blocking and no reordering. If the FIFO is non-empty and the head's channel is IDLE, the head is popped, `insn_out[ch]` is loaded, `work_en[ch]` goes to 1 for exactly one cycle, and the channel enters BUSY. If the head's channel is BUSY, the whole queue stalls.
- **Bad channel select:** if the head's channel is ≥ NUM_CH, it is popped and discarded, `err_bad_ch` is set, and nothing is issued. At most one pop occurs per cycle.
- **Done detection:** `vcu_done` is registered per channel into `done_q`. A fall is detected when `done_q & ~vcu_done`. A fall is honoured only while the channel is BUSY, and it increments `done_cnt`. A fall seen while IDLE is ignored.
- **Timeout:** the per-channel counter clears on dispatch and increments every BUSY cycle. When `timeout_limit != 0` and the counter equals `timeout_limit`, `err_timeout[ch]` is set and the channel returns to IDLE without incrementing `done_cnt`.
- **Error clear:** `err_clr` clears all sticky bits. If a new error event occurs in the same cycle as `err_clr`, the set wins.
- **Output hold:** `insn_out` holds its value until the next dispatch to that channel.

## Timing
- Push at edge E0 into an empty FIFO with the target channel IDLE gives a pop at E1. `work_en` is high from E1 to E2, `fifo_level` returns to 0 at E1, and `all_idle` is 0 from E0 until completion.
- A fall sampled at edge Ef sets the channel IDLE at Ef. A queued instruction for that channel is dispatched at Ef+1, with `work_en` high Ef+1..Ef+2. The minimum gap between `work_en` pulses on one channel is therefore 1 idle cycle after the done fall.
- A fall coinciding with a timeout in the same cycle counts as completion, with no error.
- `done_cnt` is incremented at most NUM_CH per cycle; add the simultaneous falls.
- Reset mid-operation: all outputs go to their reset values immediately, the FIFO is emptied, all channels go to IDLE, and in-flight VCU work is abandoned.
- The `done_q` reset value is 0, so a `vcu_done` held high at reset release does not create a spurious fall.

## Test plan
- **Single issue:** NUM_CH=1, push I0=0x…A5 at E0, vcu_done 0→1→0 at E5/E9.
  - `work_en` is high exactly E1–E2 and `insn_out`=I0.
  - The done fall is seen at E9, `done_cnt`=1 and `all_idle`=1.
- **Parallel channels:** push I0→ch0 and I1→ch1 on consecutive cycles.
  - Two `work_en` pulses occur one cycle apart.
  - Ch1 finishes first, then ch0; `done_cnt`=2.
- **Head-of-line block:** push ch0, ch0, ch1 while ch0 is BUSY.
  - The ch1 instruction is not issued until the second ch0 dispatch; `fifo_level` stays at 2, then 1, then 0.
- **Full FIFO:** DEPTH=4, hold ch0 BUSY and push 6 instructions.
  - `insn_ready`=0 after the 4th buffered entry (the 1st instruction is dispatched), and exactly 5 are accepted.
  - Releasing done drains them in order.
- **Timeout and bad channel:**
  - `timeout_limit`=8 with `vcu_done` held low: `err_timeout[0]`=1 after 8 BUSY cycles, the channel returns to IDLE, and `done_cnt` is unchanged.
  - Push `insn_ch`=7 with NUM_CH=2: the entry is dropped and `err_bad_ch`=1.
  - `err_clr` clears both flags.
- **Reset mid-run:** assert `rst`=0 with 3 entries queued and ch0 BUSY.
  - Outputs go to their reset values asynchronously, `fifo_level`=0 and `all_idle`=1.
  - No `work_en` pulse occurs after release until a new push.
